pq_request_sequencer: RTL and testbench
=======================================

# pq_request_sequencer

Front-end sequencer that sits directly upstream of the register-tree priority queue and drives its write/read/data controls. It accepts enqueue and dequeue requests on valid/ready handshakes and buffers enqueues in a small FIFO. It issues at most one queue operation per slot, then holds idle settle cycles so the queue's compare-and-swap passes can restore heap order. Dequeued maxima are returned on a registered valid/ready response port.

## Interface
- DATA_WIDTH, 16, key width; must match the downstream queue.
- QUEUE_SIZE, 3, downstream queue capacity, used for occupancy tracking.
- ENQ_FIFO_DEPTH, 4, enqueue buffer entries; power of two, at least 2.
- SETTLE_CYCLES, 2, idle cycles after every issued operation; at least 1.
- i_CLK  in  1  clock.
- i_RST  in  1  reset. One clock; reset is synchronous and active-high.
- i_enq_valid  in  1  enqueue request.
- o_enq_ready  out  1  enqueue FIFO not full.
- i_enq_data  in  DATA_WIDTH  key to insert.
- i_deq_valid  in  1  dequeue (pop max) request.
- o_deq_ready  out  1  no dequeue pending and response register empty.
- o_resp_valid  out  1  dequeued key available.
- i_resp_ready  in  1  consumer takes the response.
- o_resp_data  out  DATA_WIDTH  dequeued key.
- o_pq_wrt, o_pq_read  out  1 each  downstream write/read strobes.
- o_pq_data  out  DATA_WIDTH  downstream write data.
- i_pq_full, i_pq_empty  in  1 each  downstream status.
- i_pq_data  in  DATA_WIDTH  downstream root (current maximum).
- o_count  out  $clog2(QUEUE_SIZE+1)  tracked downstream occupancy.
- o_zero_drop  out  1  sticky flag: a zero key was discarded.

## Operation
- The downstream queue uses 0 as its empty-slot marker. An enqueue handshake with i_enq_data==0 completes but writes nothing to the FIFO, and sets o_zero_drop. The flag clears only on reset.
- Dequeue handshake sets a one-deep pending bit.
- FSM states are IDLE, ISSUE and SETTLE.
- **IDLE** evaluates conditions in this order:
  - Dequeue pending, FIFO non-empty, !i_pq_empty: issue REPLACE (with macro).
  - Dequeue pending, !i_pq_empty: issue READ.
  - FIFO non-empty, !i_pq_full: issue WRITE using the FIFO head.
  - Otherwise stay in IDLE.
- The chosen operation and data are latched, then the FSM goes to ISSUE.
- A dequeue pending while i_pq_empty=1 and the FIFO is empty waits; the request is not rejected.
- A dequeue pending while i_pq_empty=1 and the FIFO is non-empty is served by issuing the WRITE first.
- **ISSUE** lasts exactly one cycle and drives the strobes:
  - WRITE: o_pq_wrt=1 and o_pq_data = FIFO head; FIFO pops.
  - READ: o_pq_read=1.
  - REPLACE: both strobes = 1 and o_pq_data = FIFO head; FIFO pops.
  - For READ and REPLACE, i_pq_data is captured into the response register at the end of the cycle, and the pending bit clears.
- **SETTLE**: a down-counter runs SETTLE_CYCLES cycles with all strobes 0, then the FSM returns to IDLE.
- o_count changes at the end of ISSUE:
  - WRITE: +1.
  - READ: −1.
  - REPLACE: unchanged.
  - Saturates at 0 and QUEUE_SIZE.
- The response register holds its value until i_resp_valid&i_resp_ready, i.e. o_resp_valid && i_resp_ready. No READ or REPLACE is issued while o_resp_valid=1.
- Enqueue accept and FIFO pop in the same cycle are both honoured; FIFO occupancy is unchanged.

## Timing
- While i_RST=1 and on the cycle it deasserts:
  - All outputs are 0, including o_enq_ready, o_deq_ready and o_count.
  - The FIFO, pending bit and response register are cleared; the FSM is in IDLE.
- o_enq_ready and o_deq_ready are 1 from the first cycle after reset.
- Reset mid-operation (any state) returns to IDLE on the next edge and discards the FIFO contents and any pending dequeue. The downstream queue is reset in the same cycle; the top level inverts i_RST to drive its active-low reset.
- Enqueue accepted at edge 0 into an idle block: IDLE in cycle 1, o_pq_wrt=1 in cycle 2, SETTLE in cycles 3..2+SETTLE_CYCLES, IDLE again in cycle 3+SETTLE_CYCLES.
- Dequeue accepted at edge 0 with a non-empty queue: o_pq_read=1 in cycle 2, o_resp_valid=1 from cycle 3.
- Back-to-back throughput is one operation per 2+SETTLE_CYCLES cycles.
- Strobes are never high for two consecutive cycles.

## Configuration
- Macro: PQ_REQUEST_SEQUENCER_REPLACE_EN.
- With the macro defined: a pending dequeue plus a non-empty FIFO issues a single REPLACE (wrt=read=1).
- Without it: REPLACE is never issued. READ takes precedence, and the buffered enqueue is issued in the next IDLE slot after settling.

## Test plan
- Reset, then enqueue 5, 9, 3 (SETTLE_CYCLES=2) -> three o_pq_wrt pulses 4 cycles apart, data 5, 9, 3; o_count=3; o_enq_ready never low.
- After the above, dequeue three times with i_resp_ready=1 -> responses 9, 5, 3; o_count returns to 0.
- Enqueue key 0 -> handshake completes; no o_pq_wrt pulse; o_zero_drop=1 until reset.
- Queue holds 7; enqueue 12 and dequeue in the same cycle:
  - Macro defined: one cycle with both strobes high; response 7; o_count stays 1.
  - Macro undefined: read first (response 7), then a write of 12; o_count ends at 1.
- Fill the queue to QUEUE_SIZE=3 plus 4 FIFO entries -> o_enq_ready=0, no write issued while i_pq_full=1. After one dequeue, exactly one write follows.
- Assert i_RST during SETTLE with 2 FIFO entries and a pending dequeue -> next cycle all outputs 0, FSM in IDLE; no strobes after reset release.

Source files
------------

// File: rtl/pq_request_sequencer.sv
// pq_request_sequencer
// Front-end sequencer for the register-tree priority queue. Enqueue requests
// are buffered in a small FIFO, dequeue requests set a one-deep pending bit,
// and an IDLE/ISSUE/SETTLE FSM issues at most one queue operation per slot,
// followed by SETTLE_CYCLES idle cycles so the queue can restore heap order.
//
// Optional feature: define PQ_REQUEST_SEQUENCER_REPLACE_EN to merge a pending
// dequeue and a buffered enqueue into one REPLACE (write and read strobes
// together). Without it READ wins and the write follows in a later slot.
//
// Ports:
//   i_CLK, i_RST                 clock, synchronous active-high reset
//   i_enq_valid/o_enq_ready      enqueue handshake, key on i_enq_data
//   i_deq_valid/o_deq_ready      dequeue (pop max) handshake
//   o_resp_valid/i_resp_ready    registered response, key on o_resp_data
//   o_pq_wrt/o_pq_read/o_pq_data downstream strobes and write data
//   i_pq_full/i_pq_empty         downstream status
//   i_pq_data                    downstream root (current maximum)
//   o_count                      tracked downstream occupancy
//   o_zero_drop                  sticky: a zero key was discarded
module pq_request_sequencer #(
    parameter int DATA_WIDTH     = 16,
    parameter int QUEUE_SIZE     = 3,
    parameter int ENQ_FIFO_DEPTH = 4,
    parameter int SETTLE_CYCLES  = 2
) (
    input  logic                            i_CLK,
    input  logic                            i_RST,
    input  logic                            i_enq_valid,
    output logic                            o_enq_ready,
    input  logic [DATA_WIDTH-1:0]           i_enq_data,
    input  logic                            i_deq_valid,
    output logic                            o_deq_ready,
    output logic                            o_resp_valid,
    input  logic                            i_resp_ready,
    output logic [DATA_WIDTH-1:0]           o_resp_data,
    output logic                            o_pq_wrt,
    output logic                            o_pq_read,
    output logic [DATA_WIDTH-1:0]           o_pq_data,
    input  logic                            i_pq_full,
    input  logic                            i_pq_empty,
    input  logic [DATA_WIDTH-1:0]           i_pq_data,
    output logic [$clog2(QUEUE_SIZE+1)-1:0] o_count,
    output logic                            o_zero_drop
);

    localparam int CNT_W  = $clog2(QUEUE_SIZE + 1);
    localparam int PTR_W  = $clog2(ENQ_FIFO_DEPTH);
    localparam int FCNT_W = $clog2(ENQ_FIFO_DEPTH + 1);
    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

`ifdef PQ_REQUEST_SEQUENCER_REPLACE_EN
    localparam bit REPLACE_EN = 1'b1;
`else
    localparam bit REPLACE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_SETTLE = 2'd2} state_t;
    typedef enum logic [1:0] {OP_WRITE = 2'd0, OP_READ = 2'd1, OP_REPLACE = 2'd2} op_t;

    state_t                  state_q;
    op_t                     op_q;
    logic [DATA_WIDTH-1:0]   mem_q [ENQ_FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [FCNT_W-1:0]       fifo_cnt_q, fifo_cnt_d;
    logic                    pend_q, pend_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_data_q;
    logic                    enq_ready_q, enq_ready_d;
    logic                    deq_ready_q, deq_ready_d;
    logic                    wrt_q, read_q;
    logic [DATA_WIDTH-1:0]   pq_data_q;
    logic [CNT_W-1:0]        count_q;
    logic                    zero_drop_q;
    logic [SET_W-1:0]        settle_q;

    logic enq_fire_s, push_s, deq_fire_s, resp_fire_s;
    logic pop_s, capture_s, fifo_ne_s, can_take_s;

    assign enq_fire_s  = i_enq_valid && enq_ready_q;
    assign push_s      = enq_fire_s && (i_enq_data != DATA_WIDTH'(0));
    assign deq_fire_s  = i_deq_valid && deq_ready_q;
    assign resp_fire_s = resp_valid_q && i_resp_ready;
    // The FIFO head leaves only when the issued op actually wrote it downstream.
    assign pop_s       = (state_q == ST_ISSUE) && (op_q != OP_READ);
    // READ and REPLACE both return the old root during the issue cycle.
    assign capture_s   = (state_q == ST_ISSUE) && (op_q != OP_WRITE);
    assign fifo_ne_s   = (fifo_cnt_q != FCNT_W'(0));
    // A pop of the maximum needs a requester, a free response slot and data.
    assign can_take_s  = pend_q && !resp_valid_q && !i_pq_empty;

    // Next-state for FIFO occupancy, pending bit, response valid and the ready outputs.
    always_comb begin
        fifo_cnt_d = fifo_cnt_q + FCNT_W'(push_s) - FCNT_W'(pop_s);
        if (capture_s) begin
            pend_d = 1'b0;
        end else if (deq_fire_s) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end
        if (capture_s) begin
            resp_valid_d = 1'b1;
        end else if (resp_fire_s) begin
            resp_valid_d = 1'b0;
        end else begin
            resp_valid_d = resp_valid_q;
        end
        // Readies are registered, so they are computed from post-edge state.
        enq_ready_d = (fifo_cnt_d != FCNT_W'(ENQ_FIFO_DEPTH));
        deq_ready_d = !pend_d && !resp_valid_d;
    end

    // Sequencer FSM, FIFO storage, occupancy tracking and registered outputs.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_WRITE;
            wr_ptr_q     <= PTR_W'(0);
            rd_ptr_q     <= PTR_W'(0);
            fifo_cnt_q   <= FCNT_W'(0);
            pend_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= DATA_WIDTH'(0);
            enq_ready_q  <= 1'b0;
            deq_ready_q  <= 1'b0;
            wrt_q        <= 1'b0;
            read_q       <= 1'b0;
            pq_data_q    <= DATA_WIDTH'(0);
            count_q      <= CNT_W'(0);
            zero_drop_q  <= 1'b0;
            settle_q     <= SET_W'(0);
        end else begin
            fifo_cnt_q   <= fifo_cnt_d;
            pend_q       <= pend_d;
            resp_valid_q <= resp_valid_d;
            enq_ready_q  <= enq_ready_d;
            deq_ready_q  <= deq_ready_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= i_enq_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            // Zero is the queue's empty-slot marker, so such keys are dropped.
            if (enq_fire_s && (i_enq_data == DATA_WIDTH'(0))) begin
                zero_drop_q <= 1'b1;
            end
            if (capture_s) begin
                resp_data_q <= i_pq_data;
            end
            case (state_q)
                ST_IDLE: begin
                    if (REPLACE_EN && can_take_s && fifo_ne_s) begin
                        op_q      <= OP_REPLACE;
                        wrt_q     <= 1'b1;
                        read_q    <= 1'b1;
                        pq_data_q <= mem_q[rd_ptr_q];
                        state_q   <= ST_ISSUE;
                    end else if (can_take_s) begin
                        op_q      <= OP_READ;
                        read_q    <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end else if (fifo_ne_s && !i_pq_full) begin
                        op_q      <= OP_WRITE;
                        wrt_q     <= 1'b1;
                        pq_data_q <= mem_q[rd_ptr_q];
                        state_q   <= ST_ISSUE;
                    end else begin
                        state_q   <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    wrt_q     <= 1'b0;
                    read_q    <= 1'b0;
                    pq_data_q <= DATA_WIDTH'(0);
                    case (op_q)
                        OP_WRITE: begin
                            if (count_q != CNT_W'(QUEUE_SIZE)) begin
                                count_q <= count_q + CNT_W'(1);
                            end
                        end
                        OP_READ: begin
                            if (count_q != CNT_W'(0)) begin
                                count_q <= count_q - CNT_W'(1);
                            end
                        end
                        default: begin
                            count_q <= count_q;
                        end
                    endcase
                    settle_q <= SET_W'(SETTLE_CYCLES - 1);
                    state_q  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_q == SET_W'(0)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        settle_q <= settle_q - SET_W'(1);
                    end
                end
                default: begin
                    wrt_q     <= 1'b0;
                    read_q    <= 1'b0;
                    pq_data_q <= DATA_WIDTH'(0);
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_enq_ready  = enq_ready_q;
    assign o_deq_ready  = deq_ready_q;
    assign o_resp_valid = resp_valid_q;
    assign o_resp_data  = resp_data_q;
    assign o_pq_wrt     = wrt_q;
    assign o_pq_read    = read_q;
    assign o_pq_data    = pq_data_q;
    assign o_count      = count_q;
    assign o_zero_drop  = zero_drop_q;

endmodule

// File: tb/tb_pq_request_sequencer.sv
// Self-checking bench for pq_request_sequencer. The downstream priority queue
// is modelled as an unordered list of keys whose maximum drives i_pq_data.
`timescale 1ns/1ps
module tb_pq_request_sequencer;

    localparam int DW = 16;
    localparam int QS = 3;
    localparam int FD = 4;
    localparam int SC = 2;
    localparam int CW = $clog2(QS + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enq_valid = 1'b0;
    logic [DW-1:0] enq_data = '0;
    logic          deq_valid = 1'b0;
    logic          resp_ready = 1'b0;
    logic          enq_ready, deq_ready, resp_valid, pq_wrt, pq_read, zero_drop;
    logic [DW-1:0] resp_data, pq_data;
    logic [CW-1:0] count;
    logic          pq_full = 1'b0;
    logic          pq_empty = 1'b1;
    logic [DW-1:0] pq_root = '0;

    always #5 clk = ~clk;

    pq_request_sequencer #(
        .DATA_WIDTH(DW), .QUEUE_SIZE(QS), .ENQ_FIFO_DEPTH(FD), .SETTLE_CYCLES(SC)
    ) dut (
        .i_CLK(clk), .i_RST(rst),
        .i_enq_valid(enq_valid), .o_enq_ready(enq_ready), .i_enq_data(enq_data),
        .i_deq_valid(deq_valid), .o_deq_ready(deq_ready),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_data(resp_data),
        .o_pq_wrt(pq_wrt), .o_pq_read(pq_read), .o_pq_data(pq_data),
        .i_pq_full(pq_full), .i_pq_empty(pq_empty), .i_pq_data(pq_root),
        .o_count(count), .o_zero_drop(zero_drop)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Reference state
    logic [DW-1:0] model_pq [$];
    logic [DW-1:0] exp_wr [$];
    logic [DW-1:0] exp_resp [$];
    int            wr_hist [$];
    int            cyc = 0;
    int            wr_pulses = 0, rd_pulses = 0, both_pulses = 0, resp_cnt = 0;
    int            last_wr_cyc = 0, last_rd_cyc = 0, deq_outstanding = 0;
    logic [DW-1:0] last_resp = '0, last_wr_data = '0, smp_data = '0;
    bit            prev_strobe = 0, exp_zd = 0, smp_wr = 0, smp_rd = 0;

    function automatic logic [DW-1:0] model_max();
        logic [DW-1:0] m = '0;
        foreach (model_pq[i]) if (model_pq[i] > m) m = model_pq[i];
        return m;
    endfunction

    function automatic void model_pop_max();
        int idx = 0;
        foreach (model_pq[i]) if (model_pq[i] > model_pq[idx]) idx = i;
        if (model_pq.size() > 0) model_pq.delete(idx);
    endfunction

    // Downstream queue model: applies the strobes seen during the cycle.
    always @(posedge clk) begin
        if (rst) model_pq.delete();
        else begin
            if (smp_rd) model_pop_max();
            if (smp_wr) model_pq.push_back(smp_data);
        end
        pq_root  <= model_max();
        pq_full  <= (model_pq.size() == QS);
        pq_empty <= (model_pq.size() == 0);
        cyc      <= cyc + 1;
    end

    // Monitor: samples mid-cycle and checks the sequencing rules.
    always @(negedge clk) begin
        smp_wr = 0;
        smp_rd = 0;
        if (rst) begin
            exp_wr.delete();
            exp_resp.delete();
            deq_outstanding = 0;
            exp_zd = 0;
            prev_strobe = 0;
        end else begin
            chk("count", count, model_pq.size());
            chk("zero_drop", zero_drop, exp_zd);
            if (pq_wrt || pq_read) chk("strobe_gap", prev_strobe, 0);
            prev_strobe = pq_wrt || pq_read;
            if (pq_wrt) begin
                wr_pulses++;
                last_wr_cyc = cyc;
                last_wr_data = pq_data;
                wr_hist.push_back(cyc);
                chk("write_expected", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0) chk("write_data", pq_data, exp_wr.pop_front());
                if (!pq_read) chk("write_while_full", pq_full, 0);
                smp_wr = 1;
                smp_data = pq_data;
            end
            if (pq_read) begin
                rd_pulses++;
                last_rd_cyc = cyc;
                chk("read_while_empty", pq_empty, 0);
                chk("read_requested", deq_outstanding > 0, 1);
                deq_outstanding--;
                exp_resp.push_back(model_max());
                smp_rd = 1;
            end
            if (pq_wrt && pq_read) both_pulses++;
            if (resp_valid && resp_ready) begin
                chk("resp_expected", exp_resp.size() > 0, 1);
                if (exp_resp.size() > 0) chk("resp_data", resp_data, exp_resp.pop_front());
                last_resp = resp_data;
                resp_cnt++;
            end
            if (enq_valid && enq_ready) begin
                if (enq_data == '0) exp_zd = 1;
                else exp_wr.push_back(enq_data);
            end
            if (deq_valid && deq_ready) deq_outstanding++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_enq(input logic [DW-1:0] k);
        int t = 0;
        enq_valid = 1'b1;
        enq_data  = k;
        while (!enq_ready && t < 100) begin tick(); t++; end
        chk("enq_accept_bound", t < 100, 1);
        tick();
        enq_valid = 1'b0;
        enq_data  = '0;
    endtask

    task automatic do_deq();
        int t = 0;
        deq_valid = 1'b1;
        while (!deq_ready && t < 100) begin tick(); t++; end
        chk("deq_accept_bound", t < 100, 1);
        tick();
        deq_valid = 1'b0;
    endtask

    task automatic wait_resp(input int r0);
        int t = 0;
        while (resp_cnt == r0 && t < 60) begin tick(); t++; end
        chk("resp_seen", resp_cnt, r0 + 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_enq_ready"}, enq_ready, 0);
        chk({tag, "_deq_ready"}, deq_ready, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_data"}, resp_data, 0);
        chk({tag, "_strobes"}, {pq_wrt, pq_read}, 0);
        chk({tag, "_pq_data"}, pq_data, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_zero_drop"}, zero_drop, 0);
    endtask

    typedef struct {
        bit            is_deq;
        logic [DW-1:0] key;
        logic [DW-1:0] exp_val;
        int            exp_count;
    } vec_t;

    initial begin
        vec_t          tbl [6];
        logic [DW-1:0] deq_exp [3];
        int            t, w0, r0, b0, s0;

        tbl[0] = '{1'b0, 16'd40, 16'd40, 1};
        tbl[1] = '{1'b0, 16'd17, 16'd17, 2};
        tbl[2] = '{1'b1, 16'd0,  16'd40, 1};
        tbl[3] = '{1'b0, 16'd55, 16'd55, 2};
        tbl[4] = '{1'b1, 16'd0,  16'd55, 1};
        tbl[5] = '{1'b1, 16'd0,  16'd17, 0};
        deq_exp[0] = 16'd9;
        deq_exp[1] = 16'd5;
        deq_exp[2] = 16'd3;

        // Reset state, including the cycle in which reset is released
        tick(2);
        check_all_zero("reset");
        rst = 1'b0;
        chk("deassert_enq_ready", enq_ready, 0);
        tick();
        chk("post_reset_enq_ready", enq_ready, 1);
        chk("post_reset_deq_ready", deq_ready, 1);
        resp_ready = 1'b1;

        // Table-driven single operations
        for (int i = 0; i < 6; i++) begin
            if (!tbl[i].is_deq) begin
                w0 = wr_pulses;
                do_enq(tbl[i].key);
                t = 0;
                while (wr_pulses == w0 && t < 50) begin tick(); t++; end
                chk("tbl_wr_seen", wr_pulses, w0 + 1);
                chk("tbl_wr_data", last_wr_data, tbl[i].exp_val);
            end else begin
                r0 = resp_cnt;
                do_deq();
                wait_resp(r0);
                chk("tbl_resp", last_resp, tbl[i].exp_val);
            end
            tick(SC + 2);
            chk("tbl_count", count, tbl[i].exp_count);
        end

        // Back-to-back enqueues 5, 9, 3: one write every 2+SC cycles
        w0 = wr_pulses;
        enq_valid = 1'b1;
        enq_data = 16'd5; chk("b2b_ready0", enq_ready, 1); tick();
        enq_data = 16'd9; chk("b2b_ready1", enq_ready, 1); tick();
        enq_data = 16'd3; chk("b2b_ready2", enq_ready, 1); tick();
        enq_valid = 1'b0;
        t = 0;
        while (wr_pulses < w0 + 3 && t < 60) begin
            tick(); t++;
            chk("b2b_enq_ready_high", enq_ready, 1);
        end
        chk("b2b_writes", wr_pulses, w0 + 3);
        if (wr_hist.size() >= 3) begin
            chk("b2b_gap1", wr_hist[wr_hist.size()-2] - wr_hist[wr_hist.size()-3], SC + 2);
            chk("b2b_gap2", wr_hist[wr_hist.size()-1] - wr_hist[wr_hist.size()-2], SC + 2);
        end
        tick(SC + 2);
        chk("b2b_count", count, 3);

        // Three dequeues return the maxima in descending order
        for (int i = 0; i < 3; i++) begin
            r0 = resp_cnt;
            do_deq();
            wait_resp(r0);
            chk("deq_order", last_resp, deq_exp[i]);
        end
        tick(SC + 2);
        chk("deq_count", count, 0);

        // Zero key: handshake completes, nothing written, sticky flag
        w0 = wr_pulses;
        do_enq(16'd0);
        tick(10);
        chk("zero_no_write", wr_pulses, w0);
        chk("zero_flag", zero_drop, 1);

        // Simultaneous enqueue and dequeue with 7 already queued
        do_enq(16'd7);
        tick(SC + 6);
        w0 = wr_pulses; r0 = rd_pulses; b0 = both_pulses; s0 = resp_cnt;
        chk("sim_enq_ready", enq_ready, 1);
        chk("sim_deq_ready", deq_ready, 1);
        enq_valid = 1'b1; enq_data = 16'd12; deq_valid = 1'b1;
        tick();
        enq_valid = 1'b0; enq_data = '0; deq_valid = 1'b0;
        tick(20);
        chk("sim_writes", wr_pulses, w0 + 1);
        chk("sim_reads", rd_pulses, r0 + 1);
        chk("sim_resp_seen", resp_cnt, s0 + 1);
        chk("sim_resp", last_resp, 7);
        chk("sim_count", count, 1);
`ifdef PQ_REQUEST_SEQUENCER_REPLACE_EN
        chk("sim_both_strobes", both_pulses, b0 + 1);
        chk("sim_rd_wr_gap", last_wr_cyc - last_rd_cyc, 0);
`else
        chk("sim_both_strobes", both_pulses, b0);
        chk("sim_rd_wr_gap", last_wr_cyc - last_rd_cyc, SC + 2);
`endif
        r0 = resp_cnt;
        do_deq();
        wait_resp(r0);
        chk("sim_drain_resp", last_resp, 12);

        // Fill the queue and the FIFO
        do_enq(16'd10); do_enq(16'd20); do_enq(16'd30);
        do_enq(16'd1);  do_enq(16'd2);  do_enq(16'd3);  do_enq(16'd4);
        t = 0;
        while (count != 3 && t < 60) begin tick(); t++; end
        tick(SC + 4);
        chk("full_count", count, 3);
        chk("full_enq_ready", enq_ready, 0);
        w0 = wr_pulses;
        tick(12);
        chk("full_no_write", wr_pulses, w0);
        r0 = resp_cnt;
        do_deq();
        wait_resp(r0);
        chk("full_resp", last_resp, 30);
        tick(20);
        chk("full_one_write", wr_pulses, w0 + 1);
        chk("full_count_after", count, 3);
        chk("full_enq_ready_after", enq_ready, 1);

        // Reset during SETTLE with two buffered keys and a pending dequeue
        rst = 1'b1; tick(2); rst = 1'b0; tick();
        do_enq(16'd1); do_enq(16'd2); do_enq(16'd3);
        do_deq();
        rst = 1'b1;
        tick();
        check_all_zero("midreset");
        rst = 1'b0;
        s0 = wr_pulses + rd_pulses;
        tick(15);
        chk("midreset_no_strobes", wr_pulses + rd_pulses, s0);
        chk("midreset_count", count, 0);

        // Randomized traffic checked by the monitor
        for (int i = 0; i < 3000; i++) begin
            rst        = (i >= 1500 && i < 1502);
            enq_valid  = ($urandom_range(0, 2) == 0);
            enq_data   = ($urandom_range(0, 9) == 0) ? '0 : DW'($urandom_range(1, 65535));
            deq_valid  = ($urandom_range(0, 3) == 0);
            resp_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        rst = 1'b0; enq_valid = 1'b0; enq_data = '0;
        resp_ready = 1'b1; deq_valid = 1'b1;
        t = 0;
        while ((model_pq.size() != 0 || exp_wr.size() != 0) && t < 3000) begin tick(); t++; end
        deq_valid = 1'b0;
        tick(20);
        chk("drain_bound", t < 3000, 1);
        chk("drain_writes", exp_wr.size(), 0);
        chk("drain_resps", exp_resp.size(), 0);
        chk("drain_count", count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
